// File: rtl/decode_restart_ctrl.sv
// rtl/decode_restart_ctrl.sv - front-end restart sequencer: flush pulse, fetch redirect, decoder stall, retry trap
module decode_restart_ctrl #(
    parameter int RETRY_MAX = 3,
    parameter int CNT_W     = $clog2(RETRY_MAX + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_restart_i,
    input  logic [31:0] dec_restart_pc_i,
    input  logic        dec_jumpl_i,
    input  logic        dec_commit_i,
    input  logic        ex_resolve_i,
    input  logic [31:0] ex_resolve_pc_i,
    input  logic        ex_flush_i,
    input  logic [31:0] ex_flush_pc_i,
    input  logic        fetch_ready_i,
    input  logic        trap_ack_i,
    output logic        fe_flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        dec_stall_o,
    output logic        restart_trap_o,
    output logic [31:0] trap_pc_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        JALR_WAIT = 2'd1,
        REDIRECT  = 2'd2,
        TRAP      = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RETRY_MAX - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  retry_cnt, retry_cnt_nxt;
    logic [31:0]       last_pc, last_pc_nxt;
    logic              flush_nxt;
    logic [31:0]       redirect_pc_nxt;
    logic [31:0]       trap_pc_nxt;
    logic              redirect_valid_nxt;
    logic              dec_stall_nxt;
    logic              restart_trap_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            retry_cnt        <= '0;
            last_pc          <= '0;
            fe_flush_o       <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            dec_stall_o      <= 1'b0;
            restart_trap_o   <= 1'b0;
            trap_pc_o        <= '0;
        end else begin
            state            <= state_nxt;
            retry_cnt        <= retry_cnt_nxt;
            last_pc          <= last_pc_nxt;
            fe_flush_o       <= flush_nxt;
            redirect_valid_o <= redirect_valid_nxt;
            redirect_pc_o    <= redirect_pc_nxt;
            dec_stall_o      <= dec_stall_nxt;
            restart_trap_o   <= restart_trap_nxt;
            trap_pc_o        <= trap_pc_nxt;
        end
    end

    // Execute flush overrides everything; decoder inputs only matter in IDLE.
    always_comb begin
        state_nxt       = state;
        retry_cnt_nxt   = retry_cnt;
        last_pc_nxt     = last_pc;
        flush_nxt       = 1'b0;
        redirect_pc_nxt = redirect_pc_o;
        trap_pc_nxt     = trap_pc_o;
        if (ex_flush_i) begin
            state_nxt       = REDIRECT;
            redirect_pc_nxt = ex_flush_pc_i;
            flush_nxt       = 1'b1;
            retry_cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dec_restart_i) begin
                        if (dec_restart_pc_i == last_pc && retry_cnt == CNT_LAST) begin
                            state_nxt   = TRAP;
                            trap_pc_nxt = dec_restart_pc_i;
                        end else begin
                            if (dec_restart_pc_i == last_pc) begin
                                retry_cnt_nxt = (retry_cnt < CNT_LAST) ? retry_cnt + CNT_W'(1) : retry_cnt;
                            end else begin
                                retry_cnt_nxt = CNT_W'(1);
                            end
                            last_pc_nxt     = dec_restart_pc_i;
                            state_nxt       = REDIRECT;
                            redirect_pc_nxt = dec_restart_pc_i;
                            flush_nxt       = 1'b1;
                        end
                    end else if (dec_jumpl_i) begin
                        state_nxt = JALR_WAIT;
                    end else if (dec_commit_i) begin
                        retry_cnt_nxt = '0;
                    end
                end
                JALR_WAIT: begin
                    if (ex_resolve_i) begin
                        state_nxt       = REDIRECT;
                        redirect_pc_nxt = ex_resolve_pc_i;
                        flush_nxt       = 1'b1;
                    end
                end
                REDIRECT: begin
                    if (fetch_ready_i) begin
                        state_nxt = IDLE;
                    end
                end
                TRAP: begin
                    if (trap_ack_i) begin
                        state_nxt     = IDLE;
                        retry_cnt_nxt = '0;
                        last_pc_nxt   = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        // Targets read as zero whenever their state is not active.
        if (state_nxt != REDIRECT) redirect_pc_nxt = '0;
        if (state_nxt != TRAP)     trap_pc_nxt     = '0;
    end

    always_comb begin
        redirect_valid_nxt = (state_nxt == REDIRECT);
        dec_stall_nxt      = (state_nxt != IDLE);
        restart_trap_nxt   = (state_nxt == TRAP);
    end

endmodule

// File: tb/tb_decode_restart_ctrl.sv
// tb/tb_decode_restart_ctrl.sv - directed self-checking bench for decode_restart_ctrl
module tb_decode_restart_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_restart_i;
    logic [31:0] dec_restart_pc_i;
    logic        dec_jumpl_i;
    logic        dec_commit_i;
    logic        ex_resolve_i;
    logic [31:0] ex_resolve_pc_i;
    logic        ex_flush_i;
    logic [31:0] ex_flush_pc_i;
    logic        fetch_ready_i;
    logic        trap_ack_i;
    logic        fe_flush_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        dec_stall_o;
    logic        restart_trap_o;
    logic [31:0] trap_pc_o;

    int total = 0;
    int bad   = 0;

    logic [3:0] ctl;
    assign ctl = {fe_flush_o, redirect_valid_o, dec_stall_o, restart_trap_o};

    decode_restart_ctrl #(.RETRY_MAX(3)) dut (
        .clk              (clk),
        .rst              (rst),
        .dec_restart_i    (dec_restart_i),
        .dec_restart_pc_i (dec_restart_pc_i),
        .dec_jumpl_i      (dec_jumpl_i),
        .dec_commit_i     (dec_commit_i),
        .ex_resolve_i     (ex_resolve_i),
        .ex_resolve_pc_i  (ex_resolve_pc_i),
        .ex_flush_i       (ex_flush_i),
        .ex_flush_pc_i    (ex_flush_pc_i),
        .fetch_ready_i    (fetch_ready_i),
        .trap_ack_i       (trap_ack_i),
        .fe_flush_o       (fe_flush_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .dec_stall_o      (dec_stall_o),
        .restart_trap_o   (restart_trap_o),
        .trap_pc_o        (trap_pc_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dec_restart_i    = 1'b0;
        dec_restart_pc_i = '0;
        dec_jumpl_i      = 1'b0;
        dec_commit_i     = 1'b0;
        ex_resolve_i     = 1'b0;
        ex_resolve_pc_i  = '0;
        ex_flush_i       = 1'b0;
        ex_flush_pc_i    = '0;
        fetch_ready_i    = 1'b0;
        trap_ack_i       = 1'b0;
    endtask

    task automatic restart(input logic [31:0] pc);
        dec_restart_i = 1'b1; dec_restart_pc_i = pc;
        tick();
        dec_restart_i = 1'b0; dec_restart_pc_i = '0;
    endtask

    task automatic accept();
        fetch_ready_i = 1'b1;
        tick();
        fetch_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL reset_ctl got=%b exp=0000", ctl); end
        rst = 1'b0;
        tick();
        total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL idle_ctl got=%b exp=0000", ctl); end
        total++; if (redirect_pc_o !== 32'h0) begin bad++; $display("FAIL idle_rpc got=%h exp=0", redirect_pc_o); end
        total++; if (trap_pc_o !== 32'h0) begin bad++; $display("FAIL idle_tpc got=%h exp=0", trap_pc_o); end
    endtask

    task automatic test_restart_basic();
        restart(32'h1000);
        total++; if (ctl !== 4'b1110) begin bad++; $display("FAIL basic_ctl got=%b exp=1110", ctl); end
        total++; if (redirect_pc_o !== 32'h1000) begin bad++; $display("FAIL basic_rpc got=%h exp=1000", redirect_pc_o); end
        tick();
        total++; if (ctl !== 4'b0110) begin bad++; $display("FAIL basic_hold got=%b exp=0110", ctl); end
        tick();
        total++; if (redirect_pc_o !== 32'h1000) begin bad++; $display("FAIL basic_stable got=%h exp=1000", redirect_pc_o); end
        accept();
        total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL basic_accept got=%b exp=0000", ctl); end
        total++; if (redirect_pc_o !== 32'h0) begin bad++; $display("FAIL basic_rpc_clr got=%h exp=0", redirect_pc_o); end
    endtask

    task automatic test_retry_trap();
        restart(32'h2000);
        total++; if (ctl !== 4'b1110) begin bad++; $display("FAIL retry1 got=%b exp=1110", ctl); end
        accept();
        restart(32'h2000);
        total++; if (ctl !== 4'b1110) begin bad++; $display("FAIL retry2 got=%b exp=1110", ctl); end
        accept();
        restart(32'h2000);
        total++; if (ctl !== 4'b0011) begin bad++; $display("FAIL retry3_trap got=%b exp=0011", ctl); end
        total++; if (trap_pc_o !== 32'h2000) begin bad++; $display("FAIL trap_pc got=%h exp=2000", trap_pc_o); end
        tick();
        total++; if (ctl !== 4'b0011) begin bad++; $display("FAIL trap_hold got=%b exp=0011", ctl); end
        trap_ack_i = 1'b1;
        tick();
        trap_ack_i = 1'b0;
        total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL trap_ack got=%b exp=0000", ctl); end
        total++; if (trap_pc_o !== 32'h0) begin bad++; $display("FAIL trap_pc_clr got=%h exp=0", trap_pc_o); end
    endtask

    task automatic test_commit_clears();
        restart(32'h2000); accept();
        restart(32'h2000); accept();
        dec_commit_i = 1'b1;
        tick();
        dec_commit_i = 1'b0;
        total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL commit_idle got=%b exp=0000", ctl); end
        restart(32'h2000);
        total++; if (ctl !== 4'b1110) begin bad++; $display("FAIL commit_r1 got=%b exp=1110", ctl); end
        accept();
        restart(32'h2000);
        total++; if (ctl !== 4'b1110) begin bad++; $display("FAIL commit_r2 got=%b exp=1110", ctl); end
        accept();
        dec_commit_i = 1'b1;
        tick();
        dec_commit_i = 1'b0;
    endtask

    task automatic test_jalr();
        dec_jumpl_i = 1'b1;
        tick();
        dec_jumpl_i = 1'b0;
        total++; if (ctl !== 4'b0010) begin bad++; $display("FAIL jalr_wait got=%b exp=0010", ctl); end
        restart(32'h7777);
        total++; if (ctl !== 4'b0010) begin bad++; $display("FAIL jalr_ignore got=%b exp=0010", ctl); end
        ex_resolve_i = 1'b1; ex_resolve_pc_i = 32'h3040;
        tick();
        ex_resolve_i = 1'b0; ex_resolve_pc_i = '0;
        total++; if (ctl !== 4'b1110) begin bad++; $display("FAIL jalr_resolve got=%b exp=1110", ctl); end
        total++; if (redirect_pc_o !== 32'h3040) begin bad++; $display("FAIL jalr_rpc got=%h exp=3040", redirect_pc_o); end
        accept();
    endtask

    task automatic test_flush_during_redirect();
        restart(32'h1000);
        tick();
        total++; if (ctl !== 4'b0110) begin bad++; $display("FAIL fdr_hold got=%b exp=0110", ctl); end
        fetch_ready_i = 1'b1; ex_flush_i = 1'b1; ex_flush_pc_i = 32'h4000;
        tick();
        fetch_ready_i = 1'b0; ex_flush_i = 1'b0; ex_flush_pc_i = '0;
        total++; if (ctl !== 4'b1110) begin bad++; $display("FAIL fdr_reflush got=%b exp=1110", ctl); end
        total++; if (redirect_pc_o !== 32'h4000) begin bad++; $display("FAIL fdr_rpc got=%h exp=4000", redirect_pc_o); end
        tick();
        total++; if (ctl !== 4'b0110) begin bad++; $display("FAIL fdr_after got=%b exp=0110", ctl); end
        ex_flush_i = 1'b1; ex_flush_pc_i = 32'h4100;
        tick();
        ex_flush_pc_i = 32'h4200;
        tick();
        ex_flush_i = 1'b0; ex_flush_pc_i = '0;
        total++; if (ctl !== 4'b1110) begin bad++; $display("FAIL b2b_flush got=%b exp=1110", ctl); end
        total++; if (redirect_pc_o !== 32'h4200) begin bad++; $display("FAIL b2b_rpc got=%h exp=4200", redirect_pc_o); end
        accept();
    endtask

    task automatic test_trap_flush();
        restart(32'h5555); accept();
        restart(32'h5555); accept();
        restart(32'h5555);
        total++; if (ctl !== 4'b0011) begin bad++; $display("FAIL tf_trap got=%b exp=0011", ctl); end
        ex_flush_i = 1'b1; ex_flush_pc_i = 32'h5000;
        tick();
        ex_flush_i = 1'b0; ex_flush_pc_i = '0;
        total++; if (ctl !== 4'b1110) begin bad++; $display("FAIL tf_flush got=%b exp=1110", ctl); end
        total++; if (redirect_pc_o !== 32'h5000) begin bad++; $display("FAIL tf_rpc got=%h exp=5000", redirect_pc_o); end
        total++; if (trap_pc_o !== 32'h0) begin bad++; $display("FAIL tf_tpc got=%h exp=0", trap_pc_o); end
        accept();
    endtask

    task automatic test_async_reset();
        restart(32'h1000);
        total++; if (ctl !== 4'b1110) begin bad++; $display("FAIL ar_pre got=%b exp=1110", ctl); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL ar_ctl got=%b exp=0000", ctl); end
        total++; if (redirect_pc_o !== 32'h0) begin bad++; $display("FAIL ar_rpc got=%h exp=0", redirect_pc_o); end
        tick();
        rst = 1'b0;
        tick();
        total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL ar_idle got=%b exp=0000", ctl); end
    endtask

    initial begin
        test_reset();
        test_restart_basic();
        test_retry_trap();
        test_commit_clears();
        test_jalr();
        test_flush_during_redirect();
        test_trap_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_restart_ctrl.md
Name: decode_restart_ctrl

Overview:
- Front-end restart sequencer between the dual-issue decoder and the fetch unit.
- Collects restart causes and turns them into one registered flush pulse plus a held redirect handshake to fetch:
  - decoder restarts: mispredicted-taken on a non-branch, invalid instruction;
  - indirect-jump (jalr) waits;
  - execute-stage flushes.
- Stalls the decoder while a redirect is outstanding.
- Traps when the same PC keeps forcing restarts.

Parameters:
- RETRY_MAX, 3, consecutive decoder restarts at the same PC that raise a trap (≥2).
- CNT_W, $clog2(RETRY_MAX+1), retry counter width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- dec_restart_i  in  1  decoder restart request (invalid_prediction | invalid_instruction), qualified
- dec_restart_pc_i  in  32  PC to refetch (decoder old_pc)
- dec_jumpl_i  in  1  decoder issued a jalr; fetch target unknown
- dec_commit_i  in  1  decoder pushed ≥1 instruction to the issue queue this cycle
- ex_resolve_i  in  1  execute resolved the pending jalr target
- ex_resolve_pc_i  in  32  resolved jalr target
- ex_flush_i  in  1  execute-stage mispredict/exception flush
- ex_flush_pc_i  in  32  execute redirect PC
- fetch_ready_i  in  1  fetch accepts redirect
- trap_ack_i  in  1  trap handler acknowledges restart trap
- fe_flush_o  out  1  one-cycle flush pulse to fetch/decoder pipeline regs
- redirect_valid_o  out  1  redirect request to fetch
- redirect_pc_o  out  32  redirect target
- dec_stall_o  out  1  block decoder (drives its ready_i low)
- restart_trap_o  out  1  repeated-restart trap, level
- trap_pc_o  out  32  PC that exceeded RETRY_MAX

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all outputs 0; retry_cnt=0; last_pc=0.
  - Reset mid-operation aborts any redirect or trap immediately.
- All outputs are registered. A request sampled at edge N is visible after edge N, i.e. 1-cycle latency.
- States: IDLE, JALR_WAIT, REDIRECT, TRAP.
- Global priority, every state: ex_flush_i > ex_resolve_i > dec_restart_i > dec_jumpl_i.
- ex_flush_i in any state:
  - next=REDIRECT, redirect_pc=ex_flush_pc_i;
  - fe_flush_o=1 for exactly one cycle; retry_cnt=0; restart_trap_o cleared.
- IDLE:
  - dec_restart_i:
    - If dec_restart_pc_i==last_pc and retry_cnt==RETRY_MAX-1: next=TRAP, trap_pc_o=dec_restart_pc_i.
    - Otherwise: retry_cnt = (pc==last_pc) ? retry_cnt+1 : 1; last_pc=dec_restart_pc_i; next=REDIRECT, redirect_pc=dec_restart_pc_i, fe_flush_o pulse.
  - Else dec_jumpl_i: next=JALR_WAIT. No flush, because the jalr itself was valid.
  - Else dec_commit_i: retry_cnt=0.
- JALR_WAIT:
  - dec_stall_o=1.
  - ex_resolve_i: next=REDIRECT, redirect_pc=ex_resolve_pc_i, fe_flush_o pulse.
  - Decoder inputs are ignored; no timeout.
- REDIRECT:
  - redirect_valid_o=1, dec_stall_o=1.
  - redirect_pc_o stays stable until accepted.
  - fetch_ready_i: next=IDLE; redirect_valid_o drops the following cycle.
  - fetch_ready_i with ex_flush_i in the same cycle: stay REDIRECT with the new PC and re-pulse flush.
  - Decoder inputs are ignored.
- TRAP:
  - restart_trap_o=1, dec_stall_o=1, redirect_valid_o=0.
  - trap_ack_i: next=IDLE, retry_cnt=0, last_pc=0.
- dec_stall_o is 1 in every state except IDLE.
- fe_flush_o is never asserted on two consecutive cycles except for back-to-back ex_flush_i.
- retry_cnt saturates at RETRY_MAX-1 and never wraps.

Test Plan:
- Reset then idle:
  - all outputs 0.
  - dec_restart_i, pc=0x0000_1000, at cycle 5 → cycle 6: fe_flush_o=1, redirect_valid_o=1, redirect_pc_o=0x1000, dec_stall_o=1.
  - cycle 7: fe_flush_o=0.
  - fetch_ready_i at cycle 9 → IDLE at cycle 10.
- RETRY_MAX=3, three restarts at pc=0x2000 with no dec_commit_i between → first two redirect; third → restart_trap_o=1, trap_pc_o=0x2000, no flush. trap_ack_i → IDLE, outputs 0.
- Two restarts at 0x2000, then dec_commit_i, then 2 more at 0x2000 → no trap, because the counter was cleared.
- dec_jumpl_i → JALR_WAIT with dec_stall_o=1 and no redirect. ex_resolve_i pc=0x3040 → redirect 0x3040 with flush pulse.
- REDIRECT to 0x1000 holding (fetch_ready_i=0); ex_flush_i pc=0x4000 in the same cycle as fetch_ready_i → stay REDIRECT, redirect_pc_o=0x4000, second flush pulse.
- TRAP state plus ex_flush_i pc=0x5000 → trap cleared, REDIRECT 0x5000. Separately, rst asserted mid-REDIRECT → outputs 0 asynchronously.
